// File: rtl/xnor_link_pkg.sv
// Shared constants and types for the 6-bit XNOR descrambler datapath.
package xnor_link_pkg;

    // Data and keystream width; the LFSR taps below only make sense at 6.
    localparam int WORD_W = 6;

    // Taps for x^6 + x^5 + 1: feedback is lfsr[5] ^ lfsr[4].
    localparam logic [WORD_W-1:0] LFSR_TAPS = 6'b110000;

    // Value after reset and substitute for an all-zero seed.
    localparam logic [WORD_W-1:0] DEFAULT_SEED = 6'b100001;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Per-bit XNOR of a scrambled word with its key; undoes the transmitter's encoding.
    function automatic logic [WORD_W-1:0] xnor_word(input logic [WORD_W-1:0] data,
                                                    input logic [WORD_W-1:0] key);
        return ~(data ^ key);
    endfunction

endpackage

// File: rtl/xnor_descrambler_if.sv
// Handshake bundle between the link input register and the descrambler.
// With XNOR_DESCRAMBLER_PARITY_EN defined, the bundle also carries in_parity / par_err.
interface xnor_descrambler_if;
    import xnor_link_pkg::*;

    logic              seed_load;
    logic [WORD_W-1:0] seed_in;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              out_ready;
    logic              locked;
`ifdef XNOR_DESCRAMBLER_PARITY_EN
    logic              in_parity;
    logic              par_err;
`endif

    // Upstream/downstream side that drives the descrambler.
    modport master (
        output seed_load, seed_in, in_valid, in_data, out_ready,
`ifdef XNOR_DESCRAMBLER_PARITY_EN
        output in_parity, input par_err,
`endif
        input  in_ready, out_valid, out_data, locked
    );

    // The descrambler itself.
    modport slave (
        input  seed_load, seed_in, in_valid, in_data, out_ready,
`ifdef XNOR_DESCRAMBLER_PARITY_EN
        input  in_parity, output par_err,
`endif
        output in_ready, out_valid, out_data, locked
    );

endinterface

// File: rtl/xnor_descrambler_lfsr.sv
// Keystream generator: 6-bit Fibonacci LFSR (x^6+x^5+1, period 63).
// A zero load value is replaced by SEED so the lock-up state is unreachable.
module xnor_lfsr6
    import xnor_link_pkg::*;
#(
    parameter logic [WORD_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_val,
    input  logic              step,
    output logic [WORD_W-1:0] state
);

    logic [WORD_W-1:0] r_state;
    logic              w_feedback;
    logic [WORD_W-1:0] w_next;

    assign w_feedback = ^(r_state & LFSR_TAPS);
    assign w_next     = {r_state[WORD_W-2:0], w_feedback};

    // Register: reseed on load (zero substituted), otherwise advance once per step.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

endmodule

// File: rtl/xnor_descrambler.sv
// Streaming 6-bit XNOR descrambler: regenerates the transmitter's LFSR keystream,
// XNORs it with each accepted word and presents the result from one output register.
// Optional feature macro: XNOR_DESCRAMBLER_PARITY_EN (even-parity check, sticky par_err).
module xnor_descrambler
    import xnor_link_pkg::*;
#(
    parameter int                WIDTH = WORD_W,
    parameter logic [WORD_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                rst_n,
    xnor_descrambler_if.slave   bus
);

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_key;
    logic             w_locked;
    logic             w_in_ready;
    logic             w_accept;

    // Keystream source; steps only on an accepted word, reseeds on seed_load.
    xnor_lfsr6 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bus.seed_load),
        .load_val (bus.seed_in),
        .step     (w_accept),
        .state    (w_key)
    );

    // seed_load blocks acceptance so a word never straddles two keystreams.
    assign w_locked   = (r_state == RUN);
    assign w_in_ready = w_locked & ~bus.seed_load & (~r_out_valid | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    // Control FSM: IDLE until the first seed_load, then RUN until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (bus.seed_load) begin
            r_state <= RUN;
        end
    end

    // Output stage: load on accept, drain when downstream takes the word, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= xnor_word(bus.in_data, w_key);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef XNOR_DESCRAMBLER_PARITY_EN
    logic r_par_err;

    // Sticky parity flag: set on any accepted word with odd overall parity, cleared by reseed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (bus.seed_load) begin
            r_par_err <= 1'b0;
        end else if (w_accept && ((^bus.in_data) != bus.in_parity)) begin
            r_par_err <= 1'b1;
        end
    end

    assign bus.par_err = r_par_err;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.locked    = w_locked;

endmodule

// File: tb/tb_xnor_descrambler.sv
// Directed bench for xnor_descrambler: vector table for streaming words plus
// hand-written sequences for backpressure, reseed and reset corner cases.
// Parity checks are compiled in when XNOR_DESCRAMBLER_PARITY_EN is defined.
module tb_xnor_descrambler;
    import xnor_link_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    xnor_descrambler_if bus ();

    xnor_descrambler u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] din;
        logic [5:0] dout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_seed(input logic [5:0] s);
        bus.seed_load = 1'b1;
        bus.seed_in   = s;
        tick();
        bus.seed_load = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Keys from seed 000001: 000001,000010,000100,001000,010000,100001,000011,000110
        vecs[0] = '{6'b101010, 6'b010100};
        vecs[1] = '{6'b111111, 6'b000010};
        vecs[2] = '{6'b000000, 6'b111011};
        vecs[3] = '{6'b110011, 6'b000100};
        vecs[4] = '{6'b010101, 6'b111010};
        vecs[5] = '{6'b100001, 6'b111111};
        vecs[6] = '{6'b011100, 6'b100000};
        vecs[7] = '{6'b111001, 6'b000000};

        // ---- Reset, then IDLE ignores offered words
        rst_n         = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in   = 6'b000000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'b101010;
        bus.out_ready = 1'b1;
`ifdef XNOR_DESCRAMBLER_PARITY_EN
        bus.in_parity = 1'b0;
`endif
        repeat (3) tick();
        check("reset_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check("reset_out_data", {2'd0, bus.out_data}, 8'd0);
        check("reset_locked", {7'd0, bus.locked}, 8'd0);
        check("reset_in_ready", {7'd0, bus.in_ready}, 8'd0);
`ifdef XNOR_DESCRAMBLER_PARITY_EN
        check("reset_par_err", {7'd0, bus.par_err}, 8'd0);
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_in_ready", {7'd0, bus.in_ready}, 8'd0);
            check("idle_out_valid", {7'd0, bus.out_valid}, 8'd0);
            check("idle_locked", {7'd0, bus.locked}, 8'd0);
        end
        bus.in_valid = 1'b0;

        // ---- Seed load: locked rises after the edge, in_ready in the same cycle
        bus.seed_load = 1'b1;
        bus.seed_in   = 6'b000001;
        #1;
        check("pre_seed_locked", {7'd0, bus.locked}, 8'd0);
        tick();
        bus.seed_load = 1'b0;
        #1;
        check("seed_locked", {7'd0, bus.locked}, 8'd1);
        check("seed_in_ready", {7'd0, bus.in_ready}, 8'd1);

        // ---- Back-to-back stream, out_ready held high
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vecs[i].din;
            #1;
            check("stream_in_ready", {7'd0, bus.in_ready}, 8'd1);
            tick();
            check("stream_out_valid", {7'd0, bus.out_valid}, 8'd1);
            check($sformatf("stream_out_data[%0d]", i), {2'd0, bus.out_data}, {2'd0, vecs[i].dout});
        end
        bus.in_valid = 1'b0;
        tick();
        check("drain_out_valid", {7'd0, bus.out_valid}, 8'd0);

        // ---- Backpressure: first word held 5 cycles, second waits
        do_seed(6'b000001);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'b101010;
        #1;
        check("bp_first_ready", {7'd0, bus.in_ready}, 8'd1);
        tick();
        bus.in_data = 6'b111111;
        check("bp_first_data", {2'd0, bus.out_data}, 8'b00010100);
        check("bp_blocked_ready", {7'd0, bus.in_ready}, 8'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", {7'd0, bus.out_valid}, 8'd1);
            check("bp_hold_data", {2'd0, bus.out_data}, 8'b00010100);
            check("bp_hold_ready", {7'd0, bus.in_ready}, 8'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", {7'd0, bus.in_ready}, 8'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_second_data", {2'd0, bus.out_data}, 8'b00000010);
        check("bp_second_valid", {7'd0, bus.out_valid}, 8'd1);
        tick();
        check("bp_drain_valid", {7'd0, bus.out_valid}, 8'd0);

        // ---- Zero seed substitutes 100001
        do_seed(6'b000000);
        bus.in_valid = 1'b1;
        bus.in_data  = 6'b100001;
        tick();
        check("zero_seed_data", {2'd0, bus.out_data}, 8'b00111111);
        bus.in_data = 6'b000000;
        tick();
        check("zero_seed_step", {2'd0, bus.out_data}, 8'b00111100);

        // ---- Reseed with a pending word and a simultaneous offer
        bus.out_ready = 1'b0;
        bus.seed_load = 1'b1;
        bus.seed_in   = 6'b000001;
        bus.in_data   = 6'b101010;
        #1;
        check("reseed_in_ready", {7'd0, bus.in_ready}, 8'd0);
        tick();
        bus.seed_load = 1'b0;
        check("reseed_pending_valid", {7'd0, bus.out_valid}, 8'd1);
        check("reseed_pending_data", {2'd0, bus.out_data}, 8'b00111100);
        check("reseed_locked", {7'd0, bus.locked}, 8'd1);
        tick();
        check("reseed_hold_data", {2'd0, bus.out_data}, 8'b00111100);
        bus.out_ready = 1'b1;
        tick();
        check("reseed_new_key_data", {2'd0, bus.out_data}, 8'b00010100);
        bus.in_valid = 1'b0;
        tick();

        // ---- Period: key returns to seed after 63 accepted words
        do_seed(6'b101101);
        for (int i = 0; i < 64; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 6'b000000;
            tick();
            if (i == 0)  check("period_word0", {2'd0, bus.out_data}, 8'b00010010);
            if (i == 1)  check("period_word1", {2'd0, bus.out_data}, 8'b00100100);
            if (i == 63) check("period_word63", {2'd0, bus.out_data}, 8'b00010010);
        end
        bus.in_valid = 1'b0;
        tick();

`ifdef XNOR_DESCRAMBLER_PARITY_EN
        // ---- Parity: sticky error, word still delivered, cleared by seed_load
        do_seed(6'b000001);
        check("par_clear_on_seed", {7'd0, bus.par_err}, 8'd0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'b000001;
        bus.in_parity = 1'b0;
        tick();
        check("par_err_set", {7'd0, bus.par_err}, 8'd1);
        check("par_word_data", {2'd0, bus.out_data}, 8'b00111111);
        bus.in_data = 6'b000011;
        tick();
        check("par_next_data", {2'd0, bus.out_data}, 8'b00111110);
        check("par_err_sticky", {7'd0, bus.par_err}, 8'd1);
        bus.in_valid = 1'b0;
        repeat (2) tick();
        check("par_err_sticky_idle", {7'd0, bus.par_err}, 8'd1);
        do_seed(6'b000001);
        check("par_err_cleared", {7'd0, bus.par_err}, 8'd0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("par_good_data", {2'd0, bus.out_data}, 8'b00111101);
        check("par_good_no_err", {7'd0, bus.par_err}, 8'd0);
        tick();
`endif

        // ---- Asynchronous reset mid-operation discards a pending word
        do_seed(6'b000001);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'b101010;
        tick();
        bus.in_valid = 1'b0;
        check("areset_pending_valid", {7'd0, bus.out_valid}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check("areset_out_data", {2'd0, bus.out_data}, 8'd0);
        check("areset_locked", {7'd0, bus.locked}, 8'd0);
        check("areset_in_ready", {7'd0, bus.in_ready}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("areset_stays_idle", {7'd0, bus.locked}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
